// File: rtl/nibble_serial_adder_ctrl.sv
// Serial NIBBLES x 4-bit add/subtract sequencer with a start/ready/done handshake.
// A single 4-bit ripple slice is reused once per clock, least-significant nibble first.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);
    localparam int unsigned SEL_W = IDX_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;

    logic [SEL_W-1:0]   w_sel;
    logic [3:0]         w_sa;
    logic [3:0]         w_sb;
    logic [3:0]         w_s;
    logic [3:0]         w_c;
    logic               w_chain;

    // Bit offset of the current nibble
    assign w_sel = {r_idx, 2'b00};
    assign w_sa  = r_a[w_sel +: 4];
    assign w_sb  = r_b[w_sel +: 4];

    // 4-bit ripple slice; w_c[i] is the carry out of bit i
    always_comb begin
        w_s     = '0;
        w_c     = '0;
        w_chain = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_s[i]  = w_sa[i] ^ w_sb[i] ^ w_chain;
            w_chain = (w_sa[i] & w_sb[i]) | (w_chain & (w_sa[i] ^ w_sb[i]));
            w_c[i]  = w_chain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        r_a     <= a;
                        // Subtraction as a + ~b + 1, the +1 entering as the first carry
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                S_RUN: begin
                    sum[w_sel +: 4] <= w_s;
                    r_carry         <= w_c[3];
                    r_idx           <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(NIBBLES - 1)) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cout    <= w_c[3];
                        ovf     <= w_c[3] ^ w_c[2];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl: accepted requests push an arithmetic
// reference result; a negedge monitor pops and compares on every done pulse.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t         q[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_done_cyc = 0;
    bit           have_prev_done = 1'b0;
    bit           prev_done = 1'b0;
    bit           hold_phase = 1'b0;
    bit           have_last = 1'b0;
    logic [W-1:0] last_sum = '0;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned / signed integer arithmetic on the full operands
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int c);
        exp_t   e;
        longint ux, uy, sx, sy, sr, lim;
        lim = longint'(1) << W;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = x[W-1] ? ux - lim : ux;
        sy  = y[W-1] ? uy - lim : uy;
        if (s) begin
            e.sum  = W'(ux - uy);
            e.cout = (ux >= uy);
            sr     = sx - sy;
        end else begin
            e.sum  = W'(ux + uy);
            e.cout = ((ux + uy) >= lim);
            sr     = sx + sy;
        end
        e.ovf = (sr >= (lim >> 1)) || (sr < -(lim >> 1));
        e.cyc = c;
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst && ready && start)
            q.push_back(model(a, b, sub, cyc));
    end

    always @(negedge clk) begin
        chk("onehot_rbd", W'(int'(ready) + int'(busy) + int'(done)), W'(1));
        if (done) begin
            chk("done_width", W'(prev_done), W'(0));
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                mon_e = q.pop_front();
                chk("result_sum", sum, mon_e.sum);
                chk("result_cout", W'(cout), W'(mon_e.cout));
                chk("result_ovf", W'(ovf), W'(mon_e.ovf));
                chk("latency", W'(cyc - mon_e.cyc), W'(N));
                if (hold_phase && have_prev_done)
                    chk("b2b_spacing", W'(cyc - last_done_cyc), W'(N + 2));
                last_done_cyc  = cyc;
                have_prev_done = 1'b1;
                last_sum       = sum;
                have_last      = 1'b1;
            end
        end else if (ready && have_last) begin
            chk("sum_hold", sum, last_sum);
        end
        prev_done = done;
        cyc++;
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", W'(ready), W'(1));
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        wait_ready();
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", W'(busy), W'(1));
        chk("sum_cleared", sum, '0);
        chk("cout_cleared", W'(cout), W'(0));
        chk("ovf_cleared", W'(ovf), W'(0));
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", W'(q.size()), W'(0));
    endtask

    task automatic dchk(input string name, input logic [W-1:0] es, input logic ec, input logic eo);
        chk(name, sum, es);
        chk({name, "_cout"}, W'(cout), W'(ec));
        chk({name, "_ovf"}, W'(ovf), W'(eo));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", W'(ready), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_sum", sum, '0);
        chk("rst_cout", W'(cout), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        rst = 1'b0;

        issue(16'h1234, 16'h4321, 1'b0); drain(); dchk("add_5555", 16'h5555, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0); drain(); dchk("add_wrap", 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0); drain(); dchk("add_ovf", 16'h8000, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b1); drain(); dchk("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1); drain(); dchk("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

        // start pulsed mid-RUN must be ignored
        issue(16'h0F0F, 16'h0101, 1'b0);
        a     = 16'h1111;
        b     = 16'h2222;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        dchk("ignored_start", 16'h1010, 1'b0, 1'b0);

        // reset two cycles into RUN discards the operation
        issue(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        #2;
        rst       = 1'b1;
        q.delete();
        have_last = 1'b0;
        #1;
        chk("midrun_rst_ready", W'(ready), W'(1));
        chk("midrun_rst_busy", W'(busy), W'(0));
        chk("midrun_rst_done", W'(done), W'(0));
        chk("midrun_rst_sum", sum, '0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0); drain(); dchk("post_rst_add", 16'h0002, 1'b0, 1'b0);

        // start held high with operands changing every cycle
        @(negedge clk);
        #2;
        have_prev_done = 1'b0;
        hold_phase     = 1'b1;
        start          = 1'b1;
        repeat (20) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            #2;
        end
        start = 1'b0;
        drain();
        hold_phase = 1'b0;

        // random ops with random idle gaps
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs a NIBBLES×4-bit add or subtract by time-multiplexing a single instance of the team's 4-bit ripple adder slice (`adder`: A[3:0], B[3:0], Cin -> S[3:0], C[3:0], with C[3] as the slice carry-out). One nibble is processed per clock, least-significant nibble first, and the inter-nibble carry is held in a register. A start/ready/done handshake makes it usable as a shared arithmetic resource by an upstream controller. The block trades latency for area versus a full-width combinational adder.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  result register; held until next accepted start.
- cout  out  1  final carry-out (for sub: 1 = no borrow, a ≥ b unsigned).
- ovf  out  1  two's-complement overflow of final result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → DONE when nibble index = NIBBLES−1.
  - DONE → IDLE unconditionally.
- On accept (IDLE & start):
  - a_r <= a; b_r <= sub ? ~b : b; carry_r <= sub; idx <= 0.
  - sum, cout and ovf are cleared to 0.
- Each RUN cycle:
  - Slice inputs: A = a_r[4*idx+:4], B = b_r[4*idx+:4], Cin = carry_r.
  - sum[4*idx+:4] <= S; carry_r <= C[3]; idx <= idx+1.
- On the last nibble (idx = NIBBLES−1): cout <= C[3]; ovf <= C[3] ^ C[2].
- Width rules: result is modulo 2^W; idx is a counter of ceil(log2(NIBBLES)) bits, cleared on accept.
- start, sub, a and b are ignored outside IDLE; there is no queueing.
- sum is only meaningful when done=1 or after returning to IDLE; during RUN it holds partially written nibbles.
- The adder slice is purely combinational; the block contains no other arithmetic.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, carry_r=0, idx=0.
- Start sampled at edge E0. busy is high after E0 through E_NIBBLES. Nibble k is written at edge E(k+1).
- done is high for exactly one cycle, following edge E_NIBBLES. ready returns after edge E_NIBBLES+1.
- Earliest next accept is at edge E_NIBBLES+2. Throughput is one operation per NIBBLES+2 cycles.
- Latency from start to done: NIBBLES cycles (4 for the default).
- Reset asserted mid-RUN or mid-DONE: all state and outputs return to reset values immediately. No done pulse is produced, and the in-flight operation is discarded.
- start held high continuously: a new operation is accepted each time ready=1, with no extra cycle needed.
- ready, busy and done are mutually exclusive, and exactly one of them is high at all times.

## Test plan
- NIBBLES=4, add 0x1234 + 0x4321 -> done 4 cycles after start; sum=0x5555, cout=0, ovf=0.
- Add 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0. Add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
- Sub 0x0005 − 0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 − 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Pulse start with a=0x1111 during RUN of 0x0F0F+0x0101 -> ignored; sum=0x1010. Next op accepted only after ready=1.
- Assert rst two cycles into RUN -> ready=1, busy=0, done=0, sum=0 immediately. No done pulse; a following 0x0001+0x0001 yields 0x0002.
- Hold start=1 for 20 cycles with random operands -> back-to-back ops every 6 cycles; each result matches a scoreboard; done never lasts more than 1 cycle.
